// File: rtl/universal_shift_register_n.sv
// WIDTH-bit universal shift register with serial ports at both ends, rotate/ASR/clear
// modes, a clock enable, and a counted burst-shift command with a busy/done/err handshake.
module universal_shift_register_n #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] parallel_in,
    input  logic             ser_in_msb,
    input  logic             ser_in_lsb,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] q,
    output logic             ser_out_msb,
    output logic             ser_out_lsb,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam logic [2:0] M_HOLD  = 3'b000;
    localparam logic [2:0] M_SHR   = 3'b001;
    localparam logic [2:0] M_SHL   = 3'b010;
    localparam logic [2:0] M_LOAD  = 3'b011;
    localparam logic [2:0] M_ROR   = 3'b100;
    localparam logic [2:0] M_ROL   = 3'b101;
    localparam logic [2:0] M_ASR   = 3'b110;
    localparam logic [2:0] M_CLEAR = 3'b111;

    typedef enum logic {IDLE, BURST} state_t;

    state_t           state;
    logic [2:0]       mode_l;
    logic [CNT_W-1:0] cnt_l;
    logic [WIDTH-1:0] q_r;

    function automatic logic [WIDTH-1:0] apply_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] d,
        input logic [WIDTH-1:0] pin,
        input logic             smsb,
        input logic             slsb
    );
        logic [WIDTH-1:0] r;
        r = d;
        case (op)
            M_HOLD:  r = d;
            M_SHR:   r = {smsb, d[WIDTH-1:1]};
            M_SHL:   r = {d[WIDTH-2:0], slsb};
            M_LOAD:  r = pin;
            M_ROR:   r = {d[0], d[WIDTH-1:1]};
            M_ROL:   r = {d[WIDTH-2:0], d[WIDTH-1]};
            M_ASR:   r = {d[WIDTH-1], d[WIDTH-1:1]};
            M_CLEAR: r = '0;
            default: r = d;
        endcase
        return r;
    endfunction

    // Only the pure shift/rotate modes make sense repeated as a burst.
    function automatic logic burstable(input logic [2:0] op);
        return (op == M_SHR) || (op == M_SHL) || (op == M_ROR) ||
               (op == M_ROL) || (op == M_ASR);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            mode_l <= '0;
            cnt_l  <= '0;
            q_r    <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (burstable(mode)) begin
                            mode_l <= mode;
                            cnt_l  <= count;
                            if (count != '0) state <= BURST;
                            else             done  <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end else if (en) begin
                        q_r <= apply_op(mode, q_r, parallel_in, ser_in_msb, ser_in_lsb);
                    end
                end
                BURST: begin
                    q_r   <= apply_op(mode_l, q_r, parallel_in, ser_in_msb, ser_in_lsb);
                    cnt_l <= cnt_l - 1'b1;
                    if (cnt_l == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign q           = q_r;
    assign busy        = (state == BURST);
    assign ser_out_msb = q_r[WIDTH-1];
    assign ser_out_lsb = q_r[0];
endmodule

// File: tb/tb_universal_shift_register_n.sv
// Directed bench for universal_shift_register_n: a single-step vector table plus
// hand-written burst, zero-count, reject and reset-mid-burst sequences.
module tb_universal_shift_register_n;
    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [2:0] mode;
    logic [7:0] parallel_in;
    logic       ser_in_msb;
    logic       ser_in_lsb;
    logic       start;
    logic [3:0] count;
    logic [7:0] q;
    logic       ser_out_msb;
    logic       ser_out_lsb;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;

    universal_shift_register_n #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .parallel_in(parallel_in),
        .ser_in_msb(ser_in_msb), .ser_in_lsb(ser_in_lsb), .start(start), .count(count),
        .q(q), .ser_out_msb(ser_out_msb), .ser_out_lsb(ser_out_lsb),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] mode;
        logic       en;
        logic [7:0] pin;
        logic       smsb;
        logic       slsb;
        logic       start;
        logic [3:0] cnt;
        logic [7:0] eq;
        logic       eb;
        logic       ed;
        logic       ee;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compares q, both serial outs and the three status flags in one go.
    task automatic check_all(input string name, input logic [7:0] eq,
                             input logic eb, input logic ed, input logic ee);
        check(name, {20'd0, q, ser_out_msb, ser_out_lsb, busy, done, err},
                    {20'd0, eq, eq[7], eq[0], eb, ed, ee});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        en = 0; mode = 3'b000; parallel_in = 8'h00; ser_in_msb = 0; ser_in_lsb = 0;
        start = 0; count = 4'd0;
    endtask

    task automatic load(input logic [7:0] v);
        idle_inputs(); mode = 3'b011; parallel_in = v; en = 1;
        step();
        idle_inputs();
    endtask

    initial begin
        int busy_cycles;
        int done_seen;

        // mode en pin smsb slsb start cnt | q busy done err
        vecs[0]  = '{3'b011, 1, 8'hA5, 0, 0, 0, 4'd0, 8'hA5, 0, 0, 0};
        vecs[1]  = '{3'b011, 1, 8'h0F, 0, 0, 0, 4'd0, 8'h0F, 0, 0, 0};
        vecs[2]  = '{3'b010, 1, 8'h00, 0, 1, 0, 4'd0, 8'h1F, 0, 0, 0};
        vecs[3]  = '{3'b001, 1, 8'h00, 0, 0, 0, 4'd0, 8'h0F, 0, 0, 0};
        vecs[4]  = '{3'b001, 0, 8'h00, 1, 1, 0, 4'd0, 8'h0F, 0, 0, 0};
        vecs[5]  = '{3'b001, 1, 8'h00, 1, 0, 0, 4'd0, 8'h87, 0, 0, 0};
        vecs[6]  = '{3'b100, 1, 8'h00, 0, 0, 0, 4'd0, 8'hC3, 0, 0, 0};
        vecs[7]  = '{3'b101, 1, 8'h00, 0, 0, 0, 4'd0, 8'h87, 0, 0, 0};
        vecs[8]  = '{3'b110, 1, 8'h00, 0, 0, 0, 4'd0, 8'hC3, 0, 0, 0};
        vecs[9]  = '{3'b010, 1, 8'h00, 1, 0, 0, 4'd0, 8'h86, 0, 0, 0};
        vecs[10] = '{3'b111, 1, 8'hFF, 0, 0, 0, 4'd0, 8'h00, 0, 0, 0};
        vecs[11] = '{3'b011, 1, 8'h5A, 0, 0, 0, 4'd0, 8'h5A, 0, 0, 0};
        vecs[12] = '{3'b000, 1, 8'hFF, 1, 1, 0, 4'd0, 8'h5A, 0, 0, 0};
        vecs[13] = '{3'b011, 1, 8'hFF, 0, 0, 1, 4'd5, 8'h5A, 0, 0, 1};
        vecs[14] = '{3'b111, 1, 8'h00, 0, 0, 1, 4'd5, 8'h5A, 0, 0, 1};
        vecs[15] = '{3'b000, 0, 8'h00, 0, 0, 0, 4'd0, 8'h5A, 0, 0, 0};
        vecs[16] = '{3'b101, 1, 8'hFF, 0, 0, 1, 4'd0, 8'h5A, 0, 1, 0};
        vecs[17] = '{3'b000, 0, 8'h00, 0, 0, 0, 4'd0, 8'h5A, 0, 0, 0};

        idle_inputs();
        reset = 1;
        step(); step();
        check_all("reset_state", 8'h00, 0, 0, 0);
        reset = 0;

        for (int i = 0; i < 18; i++) begin
            mode = vecs[i].mode; en = vecs[i].en; parallel_in = vecs[i].pin;
            ser_in_msb = vecs[i].smsb; ser_in_lsb = vecs[i].slsb;
            start = vecs[i].start; count = vecs[i].cnt;
            step();
            check_all($sformatf("vec%0d", i), vecs[i].eq, vecs[i].eb, vecs[i].ed, vecs[i].ee);
        end
        idle_inputs();

        // Burst ROR of 3 with garbage on the ignored inputs mid-burst.
        load(8'hA5);
        mode = 3'b100; count = 4'd3; start = 1; en = 1;
        step();
        check_all("ror_start", 8'hA5, 1, 0, 0);
        mode = 3'b011; parallel_in = 8'hFF; count = 4'd7; start = 1; en = 1;
        step(); check_all("ror_1", 8'hD2, 1, 0, 0);
        step(); check_all("ror_2", 8'h69, 1, 0, 0);
        step(); check_all("ror_3", 8'hB4, 0, 1, 0);
        idle_inputs();
        step(); check_all("ror_after", 8'hB4, 0, 0, 0);

        // Burst ASR of 2, then a zero-count start issued while done is high.
        load(8'h90);
        mode = 3'b110; count = 4'd2; start = 1;
        step(); check_all("asr_start", 8'h90, 1, 0, 0);
        idle_inputs();
        step(); check_all("asr_1", 8'hC8, 1, 0, 0);
        step(); check_all("asr_2", 8'hE4, 0, 1, 0);
        mode = 3'b101; count = 4'd0; start = 1;
        step(); check_all("rol_zero", 8'hE4, 0, 1, 0);
        idle_inputs();
        step(); check_all("rol_zero_after", 8'hE4, 0, 0, 0);

        // Reset four shifts into a 10-step ROL burst.
        load(8'h01);
        mode = 3'b101; count = 4'd10; start = 1;
        step();
        idle_inputs();
        repeat (4) step();
        check_all("rol_4_shifts", 8'h10, 1, 0, 0);
        reset = 1;
        step(); check_all("mid_burst_reset", 8'h00, 0, 0, 0);
        reset = 0;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done || busy) done_seen++;
        end
        check("no_done_after_reset", done_seen, 0);

        // Fresh SHL burst longer than WIDTH flushes the register to ser_in_lsb.
        load(8'h81);
        mode = 3'b010; count = 4'd9; start = 1; ser_in_lsb = 1;
        step();
        start = 0; mode = 3'b000;
        busy_cycles = 0; done_seen = 0;
        for (int i = 0; i < 40 && done_seen == 0; i++) begin
            if (busy) busy_cycles++;
            step();
            if (done) done_seen = 1;
        end
        check("shl9_done_seen", done_seen, 1);
        check("shl9_busy_cycles", busy_cycles, 9);
        check_all("shl9_result", 8'hFF, 0, 1, 0);

        // Full-length ASR saturates to the sign bit.
        load(8'h80);
        mode = 3'b110; count = 4'd15; start = 1;
        step();
        idle_inputs();
        repeat (15) step();
        check_all("asr15_result", 8'hFF, 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
